// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between the load/store stage and data_mem_ctrl
// Purpose: groups the valid/ready request port, the one-cycle response pulse and busy.
// Ports (signals):
//   req_valid/req_ready  request handshake (master -> slave / slave -> master)
//   req_we, req_funct3   store flag and RV32 width code
//   req_addr, req_wdata  byte address and right-aligned store data
//   rsp_valid            one-cycle response pulse
//   rsp_rdata, rsp_err   load result and rejection flag, meaningful with rsp_valid
//   busy                 request in flight
// Modports: master (CPU side), slave (controller side).
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32 data memory controller with wait states and lane-merged stores
// Purpose: word-organised data RAM behind a valid/ready request port. Byte/half/word
//   stores merge into the existing word, loads sign/zero-extend, misaligned or
//   illegal-width accesses are rejected via rsp_err without touching memory.
//   Each legal access takes WAIT_STATES extra cycles before the memory op.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      data_mem_ctrl_if.slave (req_*, rsp_*, busy)
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  data_mem_ctrl_if.slave bus
);
  localparam int         IDX     = $clog2(MEM_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [IDX+1:0]  addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem [MEM_WORDS];

  logic            accept;
  logic            f3_bad;
  logic            misalign;
  logic            req_err;
  logic            op_fire;
  logic            op_we;
  logic [2:0]      op_f3;
  logic [IDX+1:0]  op_addr;
  logic [31:0]     op_wdata;
  logic [IDX-1:0]  op_idx;
  logic [1:0]      lane;
  logic [31:0]     rd_word;
  logic [3:0]      be;
  logic [31:0]     wd_rep;
  logic [31:0]     merged;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_data;

  // Address bits above the RAM index only cause aliasing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[ADDR_WIDTH-1:IDX+2];

  // Request decode; only meaningful while accept is high.
  always_comb begin
    accept   = bus.req_valid && (state_q == S_IDLE);
    if (bus.req_we) begin
      f3_bad = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    end else begin
      f3_bad = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    end
    misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_err  = f3_bad || misalign;
  end

  // With no wait states the op uses the live request at the accept edge;
  // otherwise it uses the captured request on the edge where the counter hits 0.
  always_comb begin
    if (state_q == S_WAIT) begin
      op_we    = we_q;
      op_f3    = f3_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end else begin
      op_we    = bus.req_we;
      op_f3    = bus.req_funct3;
      op_addr  = bus.req_addr[IDX+1:0];
      op_wdata = bus.req_wdata;
    end
    op_fire = reset_n && (((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                          (accept && !req_err && (WAIT_STATES == 0)));
    op_idx  = op_addr[IDX+1:2];
    lane    = op_addr[1:0];
    rd_word = mem[op_idx];
  end

  // Store lane merge.
  always_comb begin
    case (op_f3[1:0])
      2'b00: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{op_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = op_wdata;
      end
    endcase
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wd_rep[8*b +: 8];
    end
  end

  // Load extraction and extension.
  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_f3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (op_fire && op_we) mem[op_idx] <= merged;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (req_err || (WAIT_STATES == 0)) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter and registered response data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr[IDX+1:0];
        wdata_q <= bus.req_wdata;
        cnt_q   <= WS_LOAD;
      end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (accept && req_err) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end else if (op_fire) begin
        err_q   <= 1'b0;
        rdata_q <= op_we ? 32'd0 : load_data;
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end
endmodule
